adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Sequencer for an 8-channel, 8-bit multiplexed ADC (ADC0808-style: address/ALE, START, EOC, OE). It scans the enabled channels in ascending order once per sample period and drives the converter's control pins. Each conversion result is handed to downstream display/processing logic as a one-cycle tagged result. It replaces the hand-timed START/read counter in front of the 7-segment display path.

## Interface
Parameters:
- START_CYC, 10: cycles ALE/START are held high per conversion
- OE_CYC, 4: cycles OE is held high before the data is captured
- TIMEOUT_CYC, 1000: maximum cycles spent waiting on EOC per conversion
- PERIOD_CYC, 50000: cycles between successive scan starts (50 ms at 1 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- en  in  1  scan enable
- ch_mask  in  8  channel enable mask, bit i = channel i
- adc_eoc  in  1  converter end-of-conversion (asynchronous)
- adc_d  in  8  converter data bus
- adc_addr  out  3  channel address to converter mux
- adc_ale  out  1  address latch enable
- adc_start  out  1  conversion start
- adc_oe  out  1  converter output enable
- res_data  out  8  captured result
- res_ch  out  3  channel of res_data
- res_valid  out  1  one-cycle result strobe
- res_timeout  out  1  qualifies res_valid: conversion timed out
- busy  out  1  scan in progress

## Operation
- One clock; reset is synchronous and active-low.
- Reset values: all outputs 0, state IDLE, period counter 0.
- adc_eoc passes through a 2-flop synchronizer. All references to EOC mean the synchronized signal.
- States and transitions:
  - IDLE: when en=1 and ch_mask≠0 and the period counter has expired (or this is the first scan after reset/enable), latch ch_mask into scan_mask, select its lowest set bit, restart the period counter, go to ADDR.
  - ADDR: drive adc_addr for 1 cycle with ale/start low, then go to START.
  - START: adc_ale=adc_start=1 for START_CYC cycles, then go to WAIT_LO.
  - WAIT_LO: wait for EOC=0, then go to WAIT_HI.
  - WAIT_HI: wait for EOC=1, then go to READ.
  - READ: adc_oe=1 for OE_CYC cycles. On the last cycle, capture adc_d into res_data, then go to NEXT.
  - NEXT: pulse res_valid for 1 cycle. Advance to the next higher set bit of scan_mask and go to ADDR. If no higher set bit remains, go to IDLE.
- Timeout: a single counter covers WAIT_LO plus WAIT_HI. If it reaches TIMEOUT_CYC, go to NEXT with res_data=8'h00 and res_timeout=1. Otherwise res_timeout=0 at every res_valid.
- adc_addr holds the current channel from ADDR through NEXT. res_ch equals adc_addr at res_valid.
- busy=1 in every state except IDLE.
- The period counter runs continuously and saturates at PERIOD_CYC. If a scan outlasts PERIOD_CYC, the next scan starts in the first IDLE cycle.
- en=0 mid-scan: the current conversion completes and reports, then the block returns to IDLE. en is not re-checked until IDLE.
- ch_mask changes mid-scan are ignored until the next scan.
- ch_mask=0 with en=1: stay in IDLE, busy=0.
- rst_n=0 in any state: next cycle all outputs are 0, state IDLE, counters cleared.

## Timing
- First scan after reset with en=1 and mask≠0: ADDR is entered 1 cycle after IDLE sees the conditions.
- adc_start rises 1 cycle after adc_addr is valid (setup for ALE).
- EOC observation lags the pin by 2 cycles because of the synchronizer.
- res_valid is asserted exactly 1 cycle after the adc_oe high window ends. res_data, res_ch and res_timeout stay stable until the next res_valid.
- Minimum cycles per channel: 1 + START_CYC + 2 (sync) + 1 + 1 + OE_CYC + 1, plus the converter's conversion time.

## Structure
- Package adc_pkg holds:
  - state encoding localparams (IDLE, ADDR, START, WAIT_LO, WAIT_HI, READ, NEXT)
  - default cycle constants
  - the 8-bit result width
- Sub-module adc_eoc_sync: a 2-flop synchronizer, reset to 0.
- Next-channel selection (next set bit above the current index) is a combinational function in the main module.

## Test plan
- Reset: rst_n=0 for 3 cycles with en=1 → all outputs 0. After release, first ADDR with adc_addr=0 for mask 8'h01.
- Single channel: ch_mask=8'h04, ADC model returns 8'd173 → adc_start high 10 cycles, adc_addr=2, res_valid once with res_data=173, res_ch=2, res_timeout=0. Next scan starts 50000 cycles after the previous one.
- Sparse mask: ch_mask=8'hA1, model returns 10×channel → res_ch sequence 0, 5, 7 with data 0, 50, 70, then IDLE.
- Timeout: EOC held high → res_valid after 1000 wait cycles with res_timeout=1, res_data=0. Scan continues to the next channel.
- Mid-scan changes: en drops during channel 1 of mask 8'h0F → channel 1 still reports, then busy=0 and no channel 2. ch_mask changed mid-scan → no effect until the next scan.
- Reset mid-READ: rst_n=0 while adc_oe=1 → adc_oe=0 next cycle, no res_valid.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : adc_pkg                                                          |
// | Purpose  : Shared constants and state encoding for the ADC scan sequencer.  |
// |            Holds the result width, channel geometry, default cycle counts   |
// |            and the sequencer state type.                                    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package adc_pkg;

  // Converter geometry
  localparam int c_RES_W  = 8;   // result width
  localparam int c_NUM_CH = 8;   // multiplexer channels
  localparam int c_CH_W   = 3;   // channel address width

  // Default cycle counts
  localparam int c_START_CYC_DEF   = 10;
  localparam int c_OE_CYC_DEF      = 4;
  localparam int c_TIMEOUT_CYC_DEF = 1000;
  localparam int c_PERIOD_CYC_DEF  = 50000;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_READ    = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_eoc_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : adc_eoc_sync                                                     |
// | Purpose  : Two-flop synchronizer for the converter's asynchronous EOC pin.  |
// | Ports    : clk   in  system clock                                           |
// |            rst_n in  synchronous reset, active low (flops clear to 0)       |
// |            d     in  asynchronous input                                     |
// |            q     out synchronized output (2-cycle latency)                  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module adc_eoc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : adc_eoc_sync
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : adc_scan_ctrl                                                    |
// | Purpose  : Scan sequencer for an 8-channel multiplexed 8-bit ADC            |
// |            (ADC0808-style). Once per sample period it converts every        |
// |            enabled channel in ascending order and emits one tagged result   |
// |            per channel.                                                     |
// | Ports    : clk, rst_n         clock, synchronous active-low reset           |
// |            en, ch_mask        scan enable, channel enable mask              |
// |            adc_eoc, adc_d     converter EOC (async) and data bus            |
// |            adc_addr/ale/start/oe  converter control pins                    |
// |            res_data/ch/valid/timeout  one-cycle tagged result               |
// |            busy               scan in progress                              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int START_CYC   = c_START_CYC_DEF,
  parameter int OE_CYC      = c_OE_CYC_DEF,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
  parameter int PERIOD_CYC  = c_PERIOD_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [c_NUM_CH-1:0] ch_mask,
  input  logic                adc_eoc,
  input  logic [c_RES_W-1:0]  adc_d,
  output logic [c_CH_W-1:0]   adc_addr,
  output logic                adc_ale,
  output logic                adc_start,
  output logic                adc_oe,
  output logic [c_RES_W-1:0]  res_data,
  output logic [c_CH_W-1:0]   res_ch,
  output logic                res_valid,
  output logic                res_timeout,
  output logic                busy
);

  // One shared counter times the START window, the EOC wait and the OE window.
  localparam int c_CNT_MAX = (TIMEOUT_CYC > START_CYC) ?
                             ((TIMEOUT_CYC > OE_CYC) ? TIMEOUT_CYC : OE_CYC) :
                             ((START_CYC > OE_CYC) ? START_CYC : OE_CYC);
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
  localparam int c_PER_W = $clog2(PERIOD_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_OE_LAST    = c_CNT_W'(OE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_PER_W-1:0] c_PER_LAST   = c_PER_W'(PERIOD_CYC - 1);
  localparam logic [c_PER_W-1:0] c_PER_SAT    = c_PER_W'(PERIOD_CYC);

  // Lowest set bit of mask at index >= lo; MSB of the result flags "found".
  function automatic logic [c_CH_W:0] f_find_from(input logic [c_NUM_CH-1:0] mask,
                                                  input logic [c_CH_W:0]     lo);
    logic [c_CH_W:0] v;
    v = '0;
    for (int i = c_NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        v = {1'b1, c_CH_W'(i)};
      end
    end
    return v;
  endfunction

  logic                w_eoc_s;

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [c_PER_W-1:0]  r_period, w_period_nxt;
  logic                r_first, w_first_nxt;
  logic [c_NUM_CH-1:0] r_scan_mask, w_scan_mask_nxt;
  logic [c_CH_W-1:0]   r_ch, w_ch_nxt;
  logic [c_RES_W-1:0]  r_res_data, w_res_data_nxt;
  logic [c_CH_W-1:0]   r_res_ch, w_res_ch_nxt;
  logic                r_res_to, w_res_to_nxt;

  // Pin-level outputs are registered from the next state so the converter
  // sees glitch-free control lines that still line up with the state.
  logic                r_conv, r_oe, r_valid, r_busy;

  logic [c_CH_W:0]     w_first_ch;
  logic [c_CH_W:0]     w_next_ch;
  logic                w_period_done;

  adc_eoc_sync u_eoc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (adc_eoc),
    .q     (w_eoc_s)
  );

  assign w_first_ch    = f_find_from(ch_mask, '0);
  assign w_next_ch     = f_find_from(r_scan_mask, {1'b0, r_ch} + 1'b1);
  assign w_period_done = (r_period >= c_PER_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_period    <= '0;
      r_first     <= 1'b1;
      r_scan_mask <= '0;
      r_ch        <= '0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      r_res_to    <= 1'b0;
      r_conv      <= 1'b0;
      r_oe        <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_period    <= w_period_nxt;
      r_first     <= w_first_nxt;
      r_scan_mask <= w_scan_mask_nxt;
      r_ch        <= w_ch_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_ch    <= w_res_ch_nxt;
      r_res_to    <= w_res_to_nxt;
      r_conv      <= (w_state_nxt == ST_START);
      r_oe        <= (w_state_nxt == ST_READ);
      r_valid     <= (w_state_nxt == ST_NEXT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_first_nxt     = r_first;
    w_scan_mask_nxt = r_scan_mask;
    w_ch_nxt        = r_ch;
    w_res_data_nxt  = r_res_data;
    w_res_ch_nxt    = r_res_ch;
    w_res_to_nxt    = r_res_to;
    // Free-running, saturating period counter; restarted at each scan start.
    w_period_nxt    = (r_period == c_PER_SAT) ? r_period : r_period + 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        // Dropping en arms an immediate start on the next enable.
        if (!en) begin
          w_first_nxt = 1'b1;
        end
        if (en && (ch_mask != '0) && (r_first || w_period_done)) begin
          w_scan_mask_nxt = ch_mask;
          w_ch_nxt        = w_first_ch[c_CH_W-1:0];
          w_period_nxt    = '0;
          w_first_nxt     = 1'b0;
          w_state_nxt     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_START;
      end

      ST_START: begin
        if (r_cnt == c_START_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_LO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // The wait counter is not cleared between WAIT_LO and WAIT_HI so the
      // timeout bounds the whole EOC handshake.
      ST_WAIT_LO: begin
        if (r_cnt == c_TO_LAST) begin
          w_res_data_nxt = '0;
          w_res_to_nxt   = 1'b1;
          w_res_ch_nxt   = r_ch;
          w_state_nxt    = ST_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (!w_eoc_s) begin
            w_state_nxt = ST_WAIT_HI;
          end
        end
      end

      ST_WAIT_HI: begin
        if (w_eoc_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_READ;
        end else if (r_cnt == c_TO_LAST) begin
          w_res_data_nxt = '0;
          w_res_to_nxt   = 1'b1;
          w_res_ch_nxt   = r_ch;
          w_state_nxt    = ST_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_READ: begin
        if (r_cnt == c_OE_LAST) begin
          w_res_data_nxt = adc_d;
          w_res_to_nxt   = 1'b0;
          w_res_ch_nxt   = r_ch;
          w_state_nxt    = ST_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_NEXT: begin
        if (en && w_next_ch[c_CH_W]) begin
          w_ch_nxt    = w_next_ch[c_CH_W-1:0];
          w_state_nxt = ST_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign adc_addr    = r_ch;
  assign adc_ale     = r_conv;
  assign adc_start   = r_conv;
  assign adc_oe      = r_oe;
  assign res_data    = r_res_data;
  assign res_ch      = r_res_ch;
  assign res_valid   = r_valid;
  assign res_timeout = r_res_to;
  assign busy        = r_busy;

endmodule : adc_scan_ctrl
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_adc_scan_ctrl                                                 |
// | Purpose  : Self-checking bench for adc_scan_ctrl with a behavioural         |
// |            ADC0808 model and an expected-result queue built from the        |
// |            channel mask.                                                    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] ch_mask;
  logic       adc_eoc;
  logic [7:0] adc_d;
  logic [2:0] adc_addr;
  logic       adc_ale;
  logic       adc_start;
  logic       adc_oe;
  logic [7:0] res_data;
  logic [2:0] res_ch;
  logic       res_valid;
  logic       res_timeout;
  logic       busy;

  always #5 clk = ~clk;

  adc_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ch_mask     (ch_mask),
    .adc_eoc     (adc_eoc),
    .adc_d       (adc_d),
    .adc_addr    (adc_addr),
    .adc_ale     (adc_ale),
    .adc_start   (adc_start),
    .adc_oe      (adc_oe),
    .res_data    (res_data),
    .res_ch      (res_ch),
    .res_valid   (res_valid),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_tab [8];
  logic [7:0] to_mask;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected results of one scan: set bits in ascending order, up to 'last'.
  task automatic push_scan(input logic [7:0] m, input logic [7:0] tm, input int last);
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      if (m[c] && c <= last) begin
        e.ch   = 3'(c);
        e.to   = tm[c];
        e.data = tm[c] ? 8'h00 : data_tab[c];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag, output int at);
    int k;
    k = 0;
    while (busy !== lvl && k < bound) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    check(tag, 32'(busy), 32'(lvl));
  endtask

  // Re-arm the immediate-start path by dropping en for one cycle in IDLE.
  task automatic start_scan();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) data_tab[i] = 8'($urandom);
  endtask

  // ADC0808 model: latches the address on ALE, drops EOC a little after START
  // falls, raises it after a random conversion time, drives data while OE.
  // Channels in to_mask never drop EOC.
  initial begin
    logic       p_st;
    logic [2:0] lat;
    adc_eoc = 1'b1;
    adc_d   = 8'h00;
    p_st    = 1'b0;
    lat     = 3'd0;
    forever begin
      @(negedge clk);
      if (adc_ale) lat = adc_addr;
      if (p_st && !adc_start && !to_mask[lat]) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        adc_eoc = 1'b0;
        repeat ($urandom_range(8, 40)) @(negedge clk);
        adc_eoc = 1'b1;
      end
      p_st  = adc_start;
      adc_d = adc_oe ? data_tab[lat] : 8'($urandom);
    end
  end

  // Result and pin-timing monitor.
  initial begin
    int   s_len, a_len, o_len, fall_cyc;
    logic p_start, p_oe;
    exp_t e;
    s_len = 0; a_len = 0; o_len = 0; fall_cyc = 0;
    p_start = 1'b0; p_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_len = 0; a_len = 0; o_len = 0;
        p_start = 1'b0; p_oe = 1'b0;
        continue;
      end
      if (res_valid) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_ch", 32'(res_ch), 32'(e.ch));
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_timeout", 32'(res_timeout), 32'(e.to));
          check("res_ch_eq_addr", 32'(res_ch), 32'(adc_addr));
          if (e.to) check("timeout_latency", 32'(cyc - fall_cyc), 32'd1000);
        end
      end
      if (adc_start) s_len++;
      if (adc_ale)   a_len++;
      if (p_start && !adc_start) begin
        check("start_len", 32'(s_len), 32'd10);
        check("ale_len", 32'(a_len), 32'd10);
        fall_cyc = cyc;
        s_len = 0;
        a_len = 0;
      end
      if (adc_oe) o_len++;
      if (p_oe && !adc_oe) begin
        check("oe_len", 32'(o_len), 32'd4);
        check("valid_after_oe", 32'(res_valid), 32'd1);
        o_len = 0;
      end
      p_start = adc_start;
      p_oe    = adc_oe;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: observed cycle budget exhausted, required finish before 150000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t, t0, t1, k;
    logic [7:0] m;

    rst_n   = 1'b0;
    en      = 1'b1;
    ch_mask = 8'h01;
    to_mask = 8'h00;
    rand_data();

    // Reset held with en=1
    repeat (3) @(negedge clk);
    check("reset_outs", {7'd0, adc_addr, adc_ale, adc_start, adc_oe, res_data, res_ch,
                         res_valid, res_timeout, busy}, 32'd0);

    // First scan after reset, mask 0x01
    push_scan(8'h01, 8'h00, 7);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_busy", 32'(busy), 32'd1);
    check("first_addr", 32'(adc_addr), 32'd0);
    check("first_start_low", 32'({adc_ale, adc_start}), 32'd0);
    @(negedge clk);
    check("start_after_addr", 32'({adc_ale, adc_start}), 32'd3);
    wait_busy(1'b0, 5000, "scan0_done", t);
    check("scan0_drain", 32'(exp_q.size()), 32'd0);

    // Single channel 2 returning 173, then the periodic rescan
    ch_mask     = 8'h04;
    data_tab[2] = 8'd173;
    push_scan(8'h04, 8'h00, 7);
    push_scan(8'h04, 8'h00, 7);
    start_scan();
    wait_busy(1'b1, 10, "single_start", t0);
    check("single_addr", 32'(adc_addr), 32'd2);
    wait_busy(1'b0, 5000, "single_done", t);
    wait_busy(1'b1, 60000, "period_start", t1);
    check("period", 32'(t1 - t0), 32'd50000);
    wait_busy(1'b0, 5000, "period_done", t);
    check("single_drain", 32'(exp_q.size()), 32'd0);

    // Sparse mask, data = 10 x channel
    ch_mask = 8'hA1;
    for (int i = 0; i < 8; i++) data_tab[i] = 8'(10 * i);
    push_scan(8'hA1, 8'h00, 7);
    start_scan();
    wait_busy(1'b1, 10, "sparse_start", t);
    wait_busy(1'b0, 5000, "sparse_done", t);
    check("sparse_drain", 32'(exp_q.size()), 32'd0);

    // Channel 1 times out (EOC stuck high), channel 2 converts normally
    rand_data();
    ch_mask = 8'h06;
    to_mask = 8'h02;
    push_scan(8'h06, to_mask, 7);
    start_scan();
    wait_busy(1'b1, 10, "timeout_start", t);
    wait_busy(1'b0, 5000, "timeout_done", t);
    check("timeout_drain", 32'(exp_q.size()), 32'd0);
    to_mask = 8'h00;

    // en dropped while channel 1 of mask 0x0F is converting
    ch_mask = 8'h0F;
    push_scan(8'h0F, 8'h00, 1);
    start_scan();
    wait_busy(1'b1, 10, "drop_start", t);
    k = 0;
    while (adc_addr !== 3'd1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("drop_reach_ch1", 32'(adc_addr), 32'd1);
    en = 1'b0;
    wait_busy(1'b0, 5000, "drop_done", t);
    check("drop_drain", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    check("drop_stays_idle", 32'(busy), 32'd0);

    // ch_mask changed mid-scan takes effect only on the following scan
    ch_mask = 8'h03;
    push_scan(8'h03, 8'h00, 7);
    start_scan();
    wait_busy(1'b1, 10, "mchg_start", t);
    ch_mask = 8'hF0;
    wait_busy(1'b0, 5000, "mchg_done", t);
    check("mchg_drain", 32'(exp_q.size()), 32'd0);
    push_scan(8'hF0, 8'h00, 7);
    start_scan();
    wait_busy(1'b1, 10, "mchg2_start", t);
    wait_busy(1'b0, 5000, "mchg2_done", t);
    check("mchg2_drain", 32'(exp_q.size()), 32'd0);

    // Randomized masks, data and occasional timeouts
    for (int r = 0; r < 5; r++) begin
      m = 8'($urandom_range(1, 255));
      rand_data();
      to_mask = m & 8'($urandom) & 8'($urandom) & 8'($urandom);
      ch_mask = m;
      push_scan(m, to_mask, 7);
      start_scan();
      wait_busy(1'b1, 10, "rand_start", t);
      wait_busy(1'b0, 20000, "rand_done", t);
      check("rand_drain", 32'(exp_q.size()), 32'd0);
    end
    to_mask = 8'h00;

    // Reset asserted while OE is high
    ch_mask = 8'h01;
    push_scan(8'h01, 8'h00, 7);
    start_scan();
    wait_busy(1'b1, 10, "rstrd_start", t);
    k = 0;
    while (adc_oe !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("rstrd_reach_read", 32'(adc_oe), 32'd1);
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    check("rstrd_oe", 32'(adc_oe), 32'd0);
    check("rstrd_valid", 32'(res_valid), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("rstrd_valid_hold", 32'(res_valid), 32'd0);
    check("rstrd_res", 32'({res_data, res_ch}), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstrd_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_adc_scan_ctrl
`default_nettype wire
